// File: rtl/program_sequencer.sv
// Program sequencer for the 4-bit nibble processor: selects the next
// program-memory address and manages a small hardware return stack.
module program_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     async_reset_n,
  input  logic                     sync_reset,
  input  logic                     stall,
  input  logic                     jmp,
  input  logic                     jmp_nz,
  input  logic                     call,
  input  logic                     ret,
  input  logic [ADDR_W-1:0]        jmp_addr,
  input  logic                     r_eq_0,
  output logic [ADDR_W-1:0]        pm_addr,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     stack_ovf,
  output logic                     stack_unf
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] pc_q, pm_d, pc_inc;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [IDX_W-1:0]  wr_idx, top_idx;
  logic [SP_W-1:0]   sp_dec;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign sp_dec  = sp_q - SP_W'(1);
  assign wr_idx  = sp_q[IDX_W-1:0];
  assign top_idx = sp_dec[IDX_W-1:0];

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pm_d  = pc_inc;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (sync_reset) begin
      pm_d  = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (stall) begin
      pm_d = pc_q;
    end else if (ret) begin
      if (sp_q != '0) begin
        pm_d = stack_q[top_idx];
        sp_d = sp_dec;
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      pm_d = jmp_addr;
      if (sp_q != SP_W'(DEPTH)) begin
        push = 1'b1;
        sp_d = sp_q + SP_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (jmp || (jmp_nz && !r_eq_0)) begin
      pm_d = jmp_addr;
    end
  end

  // The fetch address is held at zero for the whole time reset is asserted.
  assign pm_addr = async_reset_n ? pm_d : '0;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pm_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // NOTE: the stack is small and must read back as zero after reset, so it is
  // built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed steps push the expected
// post-edge state into a scoreboard that is popped after each clock edge.
module tb_program_sequencer;

  localparam logic [5:0] SR   = 6'b000001;
  localparam logic [5:0] ST   = 6'b000010;
  localparam logic [5:0] JMP  = 6'b000100;
  localparam logic [5:0] JNZ  = 6'b001000;
  localparam logic [5:0] CALL = 6'b010000;
  localparam logic [5:0] RET  = 6'b100000;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic       sync_reset, stall, jmp, jmp_nz, call, ret, r_eq_0;
  logic [7:0] jmp_addr;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_ovf, stack_unf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];

  program_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .sync_reset   (sync_reset),
    .stall        (stall),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .call         (call),
    .ret          (ret),
    .jmp_addr     (jmp_addr),
    .r_eq_0       (r_eq_0),
    .pm_addr      (pm_addr),
    .pc           (pc),
    .sp           (sp),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic [5:0] ctl, input logic [7:0] addr, input logic req0);
    sync_reset = ctl[0];
    stall      = ctl[1];
    jmp        = ctl[2];
    jmp_nz     = ctl[3];
    call       = ctl[4];
    ret        = ctl[5];
    jmp_addr   = addr;
    r_eq_0     = req0;
  endtask

  // Advance one edge, then compare the registered state against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".pc"},  32'(pc),        32'(e.pc));
      check({e.tag, ".sp"},  32'(sp),        32'(e.sp));
      check({e.tag, ".ovf"}, 32'(stack_ovf), 32'(e.ovf));
      check({e.tag, ".unf"}, 32'(stack_unf), 32'(e.unf));
    end
  endtask

  task automatic apply(input string tag, input logic [5:0] ctl, input logic [7:0] addr,
                       input logic req0, input logic [7:0] exp_pm, input logic [2:0] exp_sp,
                       input logic exp_ovf, input logic exp_unf);
    exp_t e;
    set_ctl(ctl, addr, req0);
    #1;
    check({tag, ".pm"}, 32'(pm_addr), 32'(exp_pm));
    e.tag = tag; e.pc = exp_pm; e.sp = exp_sp; e.ovf = exp_ovf; e.unf = exp_unf;
    sb_q.push_back(e);
    tick();
  endtask

  initial begin
    async_reset_n = 1'b1;
    set_ctl(6'b0, 8'h00, 1'b0);
    #1 async_reset_n = 1'b0;
    #1;
    check("rst.pm",  32'(pm_addr), 32'h0);
    check("rst.pc",  32'(pc),      32'h0);
    check("rst.sp",  32'(sp),      32'h0);
    check("rst.ovf", 32'(stack_ovf), 32'h0);
    check("rst.unf", 32'(stack_unf), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold.pm", 32'(pm_addr), 32'h0);
    check("rst_hold.pc", 32'(pc),      32'h0);
    @(negedge clk);
    #1 async_reset_n = 1'b1;
    #1;
    check("rel.pm", 32'(pm_addr), 32'h01);

    // Free run and wrap
    apply("run1",  6'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    apply("run2",  6'b0, 8'h00, 1'b0, 8'h02, 3'd0, 1'b0, 1'b0);
    apply("jfe",   JMP,  8'hFE, 1'b0, 8'hFE, 3'd0, 1'b0, 1'b0);
    apply("runff", 6'b0, 8'h00, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);
    apply("wrap0", 6'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    apply("wrap1", 6'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);

    // Conditional branch
    apply("j10a",   JMP, 8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0);
    apply("jnz_tk", JNZ, 8'h40, 1'b0, 8'h40, 3'd0, 1'b0, 1'b0);
    apply("j10b",   JMP, 8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0);
    apply("jnz_nt", JNZ, 8'h40, 1'b1, 8'h11, 3'd0, 1'b0, 1'b0);

    // Nested call/ret
    apply("j05",   JMP,  8'h05, 1'b0, 8'h05, 3'd0, 1'b0, 1'b0);
    apply("call1", CALL, 8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0);
    apply("j22",   JMP,  8'h22, 1'b0, 8'h22, 3'd1, 1'b0, 1'b0);
    apply("call2", CALL, 8'h30, 1'b0, 8'h30, 3'd2, 1'b0, 1'b0);
    apply("ret1",  RET,  8'h00, 1'b0, 8'h23, 3'd1, 1'b0, 1'b0);
    apply("ret2",  RET,  8'h00, 1'b0, 8'h06, 3'd0, 1'b0, 1'b0);

    // Overflow then underflow
    apply("oc1", CALL, 8'h50, 1'b0, 8'h50, 3'd1, 1'b0, 1'b0);
    apply("oc2", CALL, 8'h60, 1'b0, 8'h60, 3'd2, 1'b0, 1'b0);
    apply("oc3", CALL, 8'h70, 1'b0, 8'h70, 3'd3, 1'b0, 1'b0);
    apply("oc4", CALL, 8'h80, 1'b0, 8'h80, 3'd4, 1'b0, 1'b0);
    apply("oc5", CALL, 8'h90, 1'b0, 8'h90, 3'd4, 1'b1, 1'b0);
    apply("or1", RET,  8'h00, 1'b0, 8'h71, 3'd3, 1'b1, 1'b0);
    apply("or2", RET,  8'h00, 1'b0, 8'h61, 3'd2, 1'b1, 1'b0);
    apply("or3", RET,  8'h00, 1'b0, 8'h51, 3'd1, 1'b1, 1'b0);
    apply("or4", RET,  8'h00, 1'b0, 8'h07, 3'd0, 1'b1, 1'b0);
    apply("or5", RET,  8'h00, 1'b0, 8'h08, 3'd0, 1'b1, 1'b1);
    apply("flags_sticky", 6'b0, 8'h00, 1'b0, 8'h09, 3'd0, 1'b1, 1'b1);
    apply("sync_rst", SR | CALL | RET, 8'h12, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Call from the top of the address space pushes the wrapped return
    apply("jff",    JMP,  8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);
    apply("callff", CALL, 8'h44, 1'b0, 8'h44, 3'd1, 1'b0, 1'b0);
    apply("retff",  RET,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Stall and priority
    apply("j33",      JMP,        8'h33, 1'b0, 8'h33, 3'd0, 1'b0, 1'b0);
    apply("st_call",  ST | CALL,  8'h20, 1'b0, 8'h33, 3'd0, 1'b0, 1'b0);
    apply("st_jmp",   ST | JMP,   8'h20, 1'b0, 8'h33, 3'd0, 1'b0, 1'b0);
    apply("call20",   CALL,       8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0);
    apply("ret_call", RET | CALL, 8'h55, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
    apply("ret_unf",  RET,        8'h00, 1'b0, 8'h35, 3'd0, 1'b0, 1'b1);
    apply("jmp_jnz",  JMP | JNZ,  8'h77, 1'b1, 8'h77, 3'd0, 1'b0, 1'b1);

    // Async reset in the middle of a call
    apply("pre_c1", CALL, 8'h10, 1'b0, 8'h10, 3'd1, 1'b0, 1'b1);
    apply("pre_c2", CALL, 8'h20, 1'b0, 8'h20, 3'd2, 1'b0, 1'b1);
    set_ctl(CALL, 8'h30, 1'b0);
    #1;
    check("mid.pm_before", 32'(pm_addr), 32'h30);
    #1 async_reset_n = 1'b0;
    #1;
    check("mid.pm",  32'(pm_addr),   32'h0);
    check("mid.pc",  32'(pc),        32'h0);
    check("mid.sp",  32'(sp),        32'h0);
    check("mid.ovf", 32'(stack_ovf), 32'h0);
    check("mid.unf", 32'(stack_unf), 32'h0);
    @(posedge clk);
    #1;
    check("mid_hold.pc", 32'(pc), 32'h0);
    check("mid_hold.sp", 32'(sp), 32'h0);
    set_ctl(6'b0, 8'h00, 1'b0);
    async_reset_n = 1'b1;
    apply("restart",   6'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    apply("no_push",   RET,  8'h00, 1'b0, 8'h02, 3'd0, 1'b0, 1'b1);

    check("sb.drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
